pipeline_hazard_ctrl: RTL and testbench

//  Sequencer for the 5-stage IF/ID/EXE/MEM/WB pipeline; the pipeline has no forwarding.
//  It detects RAW hazards between the ID-stage sources and the destinations in EXE, MEM and WB.
//  It holds fetch while a branch or jump travels to MEM, where the PC resolves it.
//  It drives the PC enable, the IF/ID enable and flush, and the ID/EXE bubble, and keeps

---
 rtl/pipeline_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/branch sequencer for a 5-stage pipeline without forwarding; hazard outputs are combinational, counters update on the clock.
// Backpressure: a RAW hazard holds PC and IF/ID and bubbles ID/EXE; a ctrl instruction holds fetch until it reaches MEM.
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int CTRL_SLOTS = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_ctrl,
  input  logic [4:0]       exe_waddr,
  input  logic             exe_wr,
  input  logic [4:0]       mem_waddr,
  input  logic             mem_wr,
  input  logic [4:0]       wb_waddr,
  input  logic             wb_wr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             ctrl_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int            CW       = (CTRL_SLOTS < 2) ? 1 : $clog2(CTRL_SLOTS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CTRL_SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    RUN       = 1'b0,
    CTRL_WAIT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          raw;
  logic          issue;

  // Writer in WB still counts: the register file updates at the edge, so ID would read stale data.
  function automatic logic dest_hit(input logic [4:0] src, input logic [4:0] dst, input logic wr);
    return wr && (dst != 5'd0) && (src == dst);
  endfunction

  function automatic logic src_match(input logic [4:0] src);
    return dest_hit(src, exe_waddr, exe_wr) ||
           dest_hit(src, mem_waddr, mem_wr) ||
           dest_hit(src, wb_waddr,  wb_wr);
  endfunction

  always_comb begin
    raw = src_match(id_rs) || (id_uses_rt && src_match(id_rt));
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    issue         = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    if (enable) begin
      case (state)
        RUN: begin
          if (raw) begin
            id_exe_bubble = 1'b1;
          end else if (id_is_ctrl) begin
            issue       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            state_nxt   = CTRL_WAIT;
            cnt_nxt     = CNT_LOAD;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
        end
        CTRL_WAIT: begin
          // Only bubbles sit in ID here, so raw is deliberately not consulted.
          if_id_en      = 1'b1;
          if_id_flush   = 1'b1;
          id_exe_bubble = 1'b1;
          if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
          end else begin
            pc_en     = 1'b1;
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (enable) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (id_exe_bubble && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (issue && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

  assign ctrl_busy = (state == CTRL_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic against a cycle-level model.
// Two instances share stimulus so the 4-bit counter instance exercises saturation.
module tb_pipeline_hazard_ctrl;
  localparam int SLOTS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, enable, id_uses_rt, id_is_ctrl, exe_wr, mem_wr, wb_wr;
  logic [4:0] id_rs, id_rt, exe_waddr, mem_waddr, wb_waddr;

  logic        pc_en, if_id_en, if_id_flush, id_exe_bubble, ctrl_busy;
  logic [15:0] stall_cycles, flush_count;
  logic        pc_en4, if_id_en4, if_id_flush4, id_exe_bubble4, ctrl_busy4;
  logic [3:0]  stall_cycles4, flush_count4;

  pipeline_hazard_ctrl #(.CNT_W(16), .CTRL_SLOTS(SLOTS)) u_dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_is_ctrl(id_is_ctrl),
    .exe_waddr(exe_waddr), .exe_wr(exe_wr), .mem_waddr(mem_waddr), .mem_wr(mem_wr),
    .wb_waddr(wb_waddr), .wb_wr(wb_wr),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_exe_bubble(id_exe_bubble), .ctrl_busy(ctrl_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.CNT_W(4), .CTRL_SLOTS(SLOTS)) u_dut4 (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_is_ctrl(id_is_ctrl),
    .exe_waddr(exe_waddr), .exe_wr(exe_wr), .mem_waddr(mem_waddr), .mem_wr(mem_wr),
    .wb_waddr(wb_waddr), .wb_wr(wb_wr),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .if_id_flush(if_id_flush4),
    .id_exe_bubble(id_exe_bubble4), .ctrl_busy(ctrl_busy4),
    .stall_cycles(stall_cycles4), .flush_count(flush_count4)
  );

  int checks = 0;
  int errors = 0;

  // Model state: remaining ctrl-wait cycles (0 = running) and plain integer counters.
  int          wait_left = 0;
  int unsigned m_stall16 = 0, m_flush16 = 0, m_stall4 = 0, m_flush4 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  function automatic bit reads_pending(input logic [4:0] src);
    logic [4:0] dst [3];
    logic       wr  [3];
    dst = '{exe_waddr, mem_waddr, wb_waddr};
    wr  = '{exe_wr, mem_wr, wb_wr};
    foreach (dst[k]) if (wr[k] && dst[k] != 0 && dst[k] == src) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_idle();
    arst_n = 1'b1; enable = 1'b1;
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_ctrl = 0;
    exe_waddr = 0; exe_wr = 0; mem_waddr = 0; mem_wr = 0; wb_waddr = 0; wb_wr = 0;
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1 time unit later.
  task automatic step();
    bit raw, e_pc, e_ifen, e_fl, e_bub, issue;
    #1;
    raw = reads_pending(id_rs) || (id_uses_rt && reads_pending(id_rt));
    e_pc = 0; e_ifen = 0; e_fl = 0; e_bub = 0; issue = 0;
    if (enable) begin
      if (wait_left > 0) begin
        e_ifen = 1; e_fl = 1; e_bub = 1;
        e_pc = (wait_left == 1);
      end else if (raw) begin
        e_bub = 1;
      end else if (id_is_ctrl) begin
        e_ifen = 1; e_fl = 1; issue = 1;
      end else begin
        e_pc = 1; e_ifen = 1;
      end
    end
    check("pc_en",         pc_en,          e_pc);
    check("if_id_en",      if_id_en,       e_ifen);
    check("if_id_flush",   if_id_flush,    e_fl);
    check("id_exe_bubble", id_exe_bubble,  e_bub);
    check("ctrl_busy",     ctrl_busy,      wait_left > 0);
    check("stall_cycles",  stall_cycles,   m_stall16);
    check("flush_count",   flush_count,    m_flush16);
    check("pc_en4",        pc_en4,         e_pc);
    check("stall_cycles4", stall_cycles4,  m_stall4);
    check("flush_count4",  flush_count4,   m_flush4);
    @(posedge clk);
    if (!arst_n) begin
      wait_left = 0;
      m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
    end else if (enable) begin
      if (e_bub) begin
        m_stall16 = sat_inc(m_stall16, 16'hFFFF);
        m_stall4  = sat_inc(m_stall4, 4'hF);
      end
      if (issue) begin
        m_flush16 = sat_inc(m_flush16, 16'hFFFF);
        m_flush4  = sat_inc(m_flush4, 4'hF);
        wait_left = SLOTS;
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    arst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_idle();

    // Reset state with a quiet pipeline
    step();

    // RAW on EXE held long enough to saturate the 4-bit counters
    id_rs = 3; exe_waddr = 3; exe_wr = 1;
    repeat (20) step();
    check("sat4_stall", stall_cycles4, 4'hF);
    check("stall16_after_20", stall_cycles, 16'd20);

    // Writes to register 0 never stall
    set_idle(); id_rs = 0; exe_waddr = 0; exe_wr = 1; mem_wr = 1; wb_wr = 1;
    repeat (2) step();

    // Plain branch
    set_idle(); id_is_ctrl = 1;
    step();
    id_is_ctrl = 0;
    repeat (3) step();
    check("flush_after_branch", flush_count, 16'd1);

    // Branch behind a load-use on rt, hazard also present via WB
    set_idle(); id_rt = 5; id_uses_rt = 1; mem_waddr = 5; mem_wr = 1; id_is_ctrl = 1;
    repeat (2) step();
    mem_wr = 0; wb_waddr = 5; wb_wr = 1;
    step();
    wb_wr = 0;
    step();
    id_is_ctrl = 0;
    repeat (3) step();

    // Hold mid-wait, then reset while in the wait
    set_idle(); id_is_ctrl = 1;
    step();
    id_is_ctrl = 0;
    step();
    enable = 0;
    repeat (4) step();
    enable = 1; arst_n = 0;
    step();
    arst_n = 1;
    check("rst_stall", stall_cycles, 16'd0);
    check("rst_flush", flush_count, 16'd0);
    repeat (2) step();

    // Random traffic over a small register range so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      arst_n     = ($urandom_range(0, 199) != 0);
      enable     = ($urandom_range(0, 9) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      id_is_ctrl = ($urandom_range(0, 5) == 0);
      exe_waddr  = 5'($urandom_range(0, 7));
      mem_waddr  = 5'($urandom_range(0, 7));
      wb_waddr   = 5'($urandom_range(0, 7));
      exe_wr     = ($urandom_range(0, 2) == 0);
      mem_wr     = ($urandom_range(0, 2) == 0);
      wb_wr      = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
